// File: rtl/mux16_rr_scheduler_pkg.sv
// mux16_rr_scheduler_pkg: sizes and FSM encoding shared by the round-robin mux scheduler
package mux16_rr_scheduler_pkg;
    localparam int N_REQ = 16;
    localparam int SEL_W = 4;
    localparam int MAX_BURST = 4;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux16_rr_scheduler_if.sv
// mux16_rr_scheduler_if: requester bank, consumer stream and arbitration status signals
interface mux16_rr_scheduler_if;
    import mux16_rr_scheduler_pkg::*;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] w;
    logic [N_REQ-1:0] grant;
    logic out_ready;
    logic out_valid;
    logic out_data;
    logic busy;
    logic [SEL_W-1:0] out_src;
    logic [SEL_W-1:0] sel;
    modport master(output req, w, out_ready, input out_valid, out_data, out_src, sel, grant, busy);
    modport slave(input req, w, out_ready, output out_valid, out_data, out_src, sel, grant, busy);
endinterface

// File: rtl/mux16_rr_scheduler_rr_pick16.sv
// mux16_rr_scheduler_rr_pick16: first set req bit at or after last+1, wrapping 15->0
module mux16_rr_scheduler_rr_pick16
    import mux16_rr_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);
    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] idx;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0] rot;
    assign start = last + SEL_W'(1);
    assign dbl = {req, req} >> start;
    assign rot = dbl[N_REQ-1:0];
    assign any = |req;
    // lowest set bit of the rotated vector wins
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) idx = SEL_W'(i);
    end
    assign pick = start + idx;
endmodule

// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin owner of a 16:1 bit mux, streaming up to MAX_BURST beats per grant
module mux16_rr_scheduler
    import mux16_rr_scheduler_pkg::*;
(
    input logic clk,
    input logic rst_n,
    mux16_rr_scheduler_if.slave bus
);
    state_t state, state_d;
    logic [SEL_W-1:0] sel, sel_d, last, last_d, pick, pick_last;
    logic [N_REQ-1:0] grant, grant_d;
    logic [CNT_W-1:0] beat_cnt, cnt_d;
    logic any, owner_req, beat, done;
    assign owner_req = bus.req[sel];
    assign bus.busy = state == GRANT;
    assign bus.out_valid = bus.busy & owner_req;
    assign bus.out_data = bus.w[sel];
    assign bus.out_src = sel;
    assign bus.sel = sel;
    assign bus.grant = grant;
    assign beat = bus.out_valid & bus.out_ready;
    assign done = bus.busy & (~owner_req | (beat & (beat_cnt == CNT_W'(MAX_BURST - 1))));
    // on release the outgoing owner becomes lowest priority for the same-edge handover
    assign pick_last = bus.busy ? sel : last;
    mux16_rr_scheduler_rr_pick16 u_pick (
        .req  (bus.req),
        .last (pick_last),
        .pick (pick),
        .any  (any)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel <= '0;
            grant <= '0;
            beat_cnt <= '0;
            last <= '1;
        end else begin
            state <= state_d;
            sel <= sel_d;
            grant <= grant_d;
            beat_cnt <= cnt_d;
            last <= last_d;
        end
    end
    always_comb begin
        state_d = state;
        sel_d = sel;
        grant_d = grant;
        cnt_d = beat_cnt;
        last_d = last;
        if (state == IDLE || done) begin
            last_d = done ? sel : last;
            state_d = any ? GRANT : IDLE;
            sel_d = any ? pick : sel;
            grant_d = any ? (N_REQ'(1) << pick) : '0;
            cnt_d = '0;
        end else if (beat) begin
            cnt_d = beat_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// tb_mux16_rr_scheduler: directed scenarios plus random traffic against a round-robin reference model
module tb_mux16_rr_scheduler;
    import mux16_rr_scheduler_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    int errors = 0;
    int checks = 0;
    mux16_rr_scheduler_if bus();
    mux16_rr_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int m_own = -1;
    int m_cnt = 0;
    int m_last = 15;
    int m_sel = 0;
    bit served;

    function automatic int pick_ref(logic [15:0] r, int from);
        for (int k = 1; k <= 16; k++) if (r[(from + k) % 16]) return (from + k) % 16;
        return -1;
    endfunction

    // owner index (-1 when idle), beats taken in current burst, previous owner
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1;
            m_cnt = 0;
            m_last = 15;
            m_sel = 0;
        end else if (m_own < 0) begin
            if (bus.req != 0) begin
                m_own = pick_ref(bus.req, m_last);
                m_sel = m_own;
                m_cnt = 0;
            end
        end else begin
            served = bus.req[m_own] && bus.out_ready;
            if (!bus.req[m_own] || (served && m_cnt == MAX_BURST - 1)) begin
                m_last = m_own;
                m_cnt = 0;
                if (bus.req != 0) begin
                    m_own = pick_ref(bus.req, m_last);
                    m_sel = m_own;
                end else m_own = -1;
            end else if (served) m_cnt++;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 16'hFFFF;
        bus.w = 16'h0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.grant !== 16'h0) begin errors++; $display("FAIL reset_grant got=%h exp=0000", bus.grant); end
        checks++; if (bus.sel !== 4'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 16'h0001) begin errors++; $display("FAIL reset_first_grant got=%h exp=0001", bus.grant); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy got=%b exp=1", bus.busy); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 16'h0008;
        bus.w = 16'hACD1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.sel !== 4'd3) begin errors++; $display("FAIL single_sel got=%0d exp=3", bus.sel); end
        checks++; if (bus.out_data !== 1'b0) begin errors++; $display("FAIL single_data got=%b exp=0", bus.out_data); end
        checks++; if (bus.grant !== 16'h0008) begin errors++; $display("FAIL single_grant got=%h exp=0008", bus.grant); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (bus.sel !== 4'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_regrant cyc=%0d got sel=%0d valid=%b exp sel=3 valid=1", i, bus.sel, bus.out_valid); end
            checks++; if (dut.beat_cnt !== 3'((i + 1) % 4)) begin errors++; $display("FAIL single_cnt cyc=%0d got=%0d exp=%0d", i, dut.beat_cnt, (i + 1) % 4); end
        end
    endtask

    task automatic test_all();
        int e;
        apply_reset();
        bus.req = 16'hFFFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 68; i++) begin
            @(negedge clk);
            e = (i / 4) % 16;
            checks++; if (bus.sel !== 4'(e)) begin errors++; $display("FAIL all_sel cyc=%0d got=%0d exp=%0d", i, bus.sel, e); end
            checks++; if (bus.grant !== (16'h1 << e)) begin errors++; $display("FAIL all_grant cyc=%0d got=%h exp=%h", i, bus.grant, 16'h1 << e); end
        end
    endtask

    task automatic test_wrap();
        int e;
        apply_reset();
        bus.req = 16'h4000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.sel !== 4'd14) begin errors++; $display("FAIL wrap_setup got=%0d exp=14", bus.sel); end
        bus.req = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = ((i / 4) % 2 == 0) ? 15 : 0;
            checks++; if (bus.sel !== 4'(e)) begin errors++; $display("FAIL wrap_15_0 cyc=%0d got=%0d exp=%0d", i, bus.sel, e); end
        end
        bus.req = 16'h4004;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = ((i / 4) % 2 == 0) ? 2 : 14;
            checks++; if (bus.sel !== 4'(e)) begin errors++; $display("FAIL wrap_2_14 cyc=%0d got=%0d exp=%0d", i, bus.sel, e); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.req = 16'h0060;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.sel !== 4'd5) begin errors++; $display("FAIL bp_sel got=%0d exp=5", bus.sel); end
        @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (bus.sel !== 4'd5 || bus.grant !== 16'h0020 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got sel=%0d grant=%h valid=%b exp 5/0020/1", i, bus.sel, bus.grant, bus.out_valid); end
            checks++; if (dut.beat_cnt !== 3'd2) begin errors++; $display("FAIL bp_cnt cyc=%0d got=%0d exp=2", i, dut.beat_cnt); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.sel !== 4'd5) begin errors++; $display("FAIL bp_beat3 got=%0d exp=5", bus.sel); end
        @(negedge clk);
        checks++; if (bus.sel !== 4'd6) begin errors++; $display("FAIL bp_rotate got=%0d exp=6", bus.sel); end
    endtask

    task automatic test_drop_reset();
        apply_reset();
        bus.req = 16'h0022;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.sel !== 4'd1) begin errors++; $display("FAIL drop_first got=%0d exp=1", bus.sel); end
        @(negedge clk);
        bus.req = 16'h0020;
        @(negedge clk);
        checks++; if (bus.sel !== 4'd5) begin errors++; $display("FAIL drop_sel got=%0d exp=5", bus.sel); end
        checks++; if (dut.beat_cnt !== 3'd0) begin errors++; $display("FAIL drop_cnt got=%0d exp=0", dut.beat_cnt); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 16'h0 || bus.sel !== 4'd0) begin errors++; $display("FAIL async_rst got grant=%h sel=%0d exp 0000/0", bus.grant, bus.sel); end
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL async_rst_flags got valid=%b busy=%b exp 0/0", bus.out_valid, bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] eg;
        logic ev;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0)
                bus.req = ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom) & 16'($urandom) & 16'($urandom);
            bus.w = 16'($urandom);
            bus.out_ready = $urandom_range(3) != 0;
            #1;
            eg = (m_own >= 0) ? (16'h1 << m_own) : 16'h0;
            ev = (m_own >= 0) ? bus.req[m_own] : 1'b0;
            checks++; if (bus.sel !== 4'(m_sel) || bus.out_src !== 4'(m_sel)) begin errors++; $display("FAIL rand_sel cyc=%0d got sel=%0d src=%0d exp=%0d", c, bus.sel, bus.out_src, m_sel); end
            checks++; if (bus.grant !== eg) begin errors++; $display("FAIL rand_grant cyc=%0d got=%h exp=%h", c, bus.grant, eg); end
            checks++; if (bus.busy !== (m_own >= 0) || bus.out_valid !== ev) begin errors++; $display("FAIL rand_flags cyc=%0d got busy=%b valid=%b exp busy=%b valid=%b", c, bus.busy, bus.out_valid, m_own >= 0, ev); end
            checks++; if (bus.out_data !== bus.w[m_sel]) begin errors++; $display("FAIL rand_data cyc=%0d got=%b exp=%b", c, bus.out_data, bus.w[m_sel]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_wrap();
        test_backpressure();
        test_drop_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
